// File: rtl/accum_tile_controller.sv
// accum_tile_controller: sequences one output tile through the ROWS x COLS
// accumulator bank. It clears the bank, accumulates num_tiles partial-sum
// tiles, waits one settle cycle, then drains the bank one row per beat.
// Optional build macro: ACC_CTRL_PERF_EN adds the stall_cycles counter port.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one-cycle bank clear
// ACCUM  | accept partial-sum tiles, one enable per handshake
// SETTLE | last bank update registers; overflow flag sampled
// DRAIN  | stream bank rows out over valid/ready
// DONE   | one-cycle completion pulse
module accum_tile_controller #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int ACC_WIDTH  = 32,
    parameter  int TILE_CNT_W = 16,
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [TILE_CNT_W-1:0]           num_tiles,
    input  logic                            abort,
    output logic                            busy,
    output logic                            done,
    input  logic                            psum_valid,
    output logic                            psum_ready,
    output logic                            acc_clear,
    output logic                            acc_enable,
    input  logic                            acc_overflow,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0]  acc_sums,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [COLS*ACC_WIDTH-1:0]       out_row,
    output logic [ROW_W-1:0]                out_row_idx,
    output logic                            overflow_status
`ifdef ACC_CTRL_PERF_EN
    ,
    output logic [31:0]                     stall_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        SETTLE = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [TILE_CNT_W-1:0] tile_cnt;
    logic [TILE_CNT_W-1:0] num_lat;
    logic [ROW_W-1:0]      row;
    logic                  start_ok;
    logic                  last_tile;
    logic                  last_row;

    assign start_ok  = (state == IDLE) && start;
    assign last_tile = (tile_cnt == num_lat - TILE_CNT_W'(1));
    assign last_row  = (row == ROW_W'(ROWS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and control outputs; abort overrides everything outside IDLE
    always_comb begin
        state_n    = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        psum_ready = 1'b0;
        acc_clear  = 1'b0;
        out_valid  = 1'b0;
        if ((state != IDLE) && abort) begin
            state_n   = IDLE;
            acc_clear = 1'b1;
        end else begin
            case (state)
                IDLE:   if (start) state_n = (num_tiles == '0) ? DONE : CLEAR;
                CLEAR: begin
                    acc_clear = 1'b1;
                    state_n   = ACCUM;
                end
                ACCUM: begin
                    psum_ready = 1'b1;
                    if (psum_valid && last_tile) state_n = SETTLE;
                end
                SETTLE: state_n = DRAIN;
                DRAIN: begin
                    out_valid = 1'b1;
                    if (out_ready && last_row) state_n = DONE;
                end
                DONE: begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign acc_enable  = psum_valid & psum_ready;
    assign out_row_idx = row;
    assign out_row     = (state == DRAIN) ?
                         acc_sums[int'(row) * COLS * ACC_WIDTH +: COLS * ACC_WIDTH] : '0;

    // Job bookkeeping: latched length, tile/row counters, overflow status
    always_ff @(posedge clk) begin
        if (reset) begin
            tile_cnt        <= '0;
            num_lat         <= '0;
            row             <= '0;
            overflow_status <= 1'b0;
        end else begin
            if (start_ok) begin
                num_lat         <= num_tiles;
                tile_cnt        <= '0;
                overflow_status <= 1'b0;
            end else if (acc_enable) begin
                tile_cnt <= tile_cnt + TILE_CNT_W'(1);
            end
            if (state == SETTLE && !abort) overflow_status <= acc_overflow;
            if (busy && abort)              row <= '0;
            else if (state == SETTLE)       row <= '0;
            else if (out_valid && out_ready) row <= last_row ? '0 : row + ROW_W'(1);
        end
    end

`ifdef ACC_CTRL_PERF_EN
    // Saturating count of input-starved ACCUM and back-pressured DRAIN cycles
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (start_ok)
            stall_cycles <= '0;
        else if (((state == ACCUM && !psum_valid) || (state == DRAIN && !out_ready))
                 && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: doc/accum_tile_controller.md
Name: accum_tile_controller

Overview:
- Sequences one output tile through the 4x4 accumulator bank.
- On start it clears the bank, then issues one accumulate-enable per accepted partial-sum tile from the systolic array, for num_tiles K-slices.
- It then streams the accumulated result out row by row over a valid/ready interface.
- Sits between the array/scheduler front end and the output writeback path.

Parameters:
- ROWS, 4, bank rows; drained one row per beat.
- COLS, 4, bank columns; each drain beat carries COLS words.
- ACC_WIDTH, 32, accumulator word width, signed two's complement.
- TILE_CNT_W, 16, width of num_tiles and the internal tile counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a tile job; sampled only in IDLE.
- num_tiles  in  TILE_CNT_W  K-slices to accumulate; latched on start.
- abort  in  1  cancel the job in progress.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the job completes.
- psum_valid  in  1  partial-sum tile present at the bank input.
- psum_ready  out  1  controller accepts a partial-sum tile.
- acc_clear  out  1  to bank clear.
- acc_enable  out  1  to bank enable.
- acc_overflow  in  1  bank sticky overflow flag.
- acc_sums  in  ROWS*COLS*ACC_WIDTH  flattened bank outputs; row r col c at bits [(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH].
- out_valid  out  1  drain row valid.
- out_ready  in  1  downstream accepts the row.
- out_row  out  COLS*ACC_WIDTH  current row; col c at [c*ACC_WIDTH +: ACC_WIDTH].
- out_row_idx  out  clog2(ROWS) max 1  index of the current row.
- overflow_status  out  1  job overflowed; valid from DRAIN through next start.

Behaviour:
- States: IDLE, CLEAR, ACCUM, SETTLE, DRAIN, DONE. Reset forces IDLE.
- Reset values: all outputs 0; tile counter, row counter and latched num_tiles are 0.
- IDLE:
  - start accepted: latch num_tiles, clear overflow_status.
  - If num_tiles==0, go to DONE. No clear is issued and no drain occurs.
  - Otherwise go to CLEAR.
- CLEAR: acc_clear=1 for exactly one cycle, then ACCUM.
- ACCUM:
  - psum_ready=1.
  - acc_enable = psum_valid & psum_ready, combinational, in the same cycle.
  - The tile counter increments on each handshake.
  - A handshake while the count equals num_tiles-1 moves to SETTLE.
  - psum_valid low stalls with no enable.
- SETTLE: one cycle so the last bank update is registered; overflow_status <= acc_overflow. Then DRAIN with row=0.
- DRAIN:
  - out_valid=1; out_row/out_row_idx select the current row from acc_sums.
  - Both stay stable while out_ready=0.
  - A handshake advances the row; the handshake on row ROWS-1 moves to DONE.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE.
- Latency with psum_valid and out_ready held high:
  - start sampled at cycle 0: CLEAR at 1, ACCUM at 2..N+1, SETTLE at N+2.
  - DRAIN at N+3..N+2+ROWS, done at N+3+ROWS.
- abort:
  - In any non-IDLE state, abort has priority over all other transitions.
  - Next state is IDLE, acc_clear=1 in the abort cycle.
  - No psum_ready, acc_enable, out_valid or done in that cycle.
  - Ignored in IDLE.
- psum_ready, acc_enable and out_valid are never high outside ACCUM/DRAIN.
- acc_clear and acc_enable are never both high.
- start while busy: ignored; no relatch.

Optional Feature:
- Macro ACC_CTRL_PERF_EN.
- When defined: adds output stall_cycles, 32 bits.
  - Counts ACCUM cycles with psum_valid=0, plus DRAIN cycles with out_ready=0.
  - Saturates at all-ones, clears on an accepted start, resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Job, num_tiles=3, psum_valid and out_ready constant 1, start at cycle 0:
  - acc_clear at cycle 1; acc_enable at cycles 2-4; out_valid at cycles 6-9 with idx 0..3; done at cycle 10; busy low at cycle 11.
- Job, num_tiles=2, psum_valid low for 3 cycles between tiles, out_ready low for 2 cycles on row 1:
  - Exactly 2 acc_enable pulses; row 1 data held stable; done arrives 5 cycles later than the unstalled case.
  - With ACC_CTRL_PERF_EN defined: stall_cycles=5.
- Job, num_tiles=0: done pulses 1 cycle after start; acc_clear, acc_enable and out_valid are never asserted.
- abort during ACCUM after 1 of 4 tiles: acc_clear=1 in the abort cycle, IDLE next cycle, no done. A following start with num_tiles=1 completes normally.
- Bank drives acc_overflow=1 before SETTLE: overflow_status=1 during DRAIN and after done; it clears on the next accepted start.
- Assert reset in DRAIN row 2, then assert start during DONE of a later job:
  - After reset: IDLE and all outputs 0.
  - The start during DONE is ignored; busy stays low after done.
